// File: rtl/arm7tdmi_shift_pipe.sv
// ARM7TDMI operand-2 barrel shifter: LSL/LSR/ASR/ROR, RRX, #0 re-encodings, register amounts >= DATA_W.
// Latency: 1 cycle; 2 cycles when ARM7_SHIFT_PIPE2_EN is defined (register between decode A and shift B).
// Backpressure: valid/ready; a stalled result holds stable, flush drops everything in flight, in_ready follows out_ready.
module arm7tdmi_shift_pipe #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_type,
    input  logic [AMT_W-1:0]  in_amount,
    input  logic              in_imm,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int          L   = $clog2(DATA_W);
    localparam int          EW  = L + 1;
    localparam logic [31:0] W32 = DATA_W;

    typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} shift_type_t;

    typedef struct packed {
        shift_type_t       typ;
        logic [EW-1:0]     amt;
        logic              pass;
        logic              rrx;
        logic              zero;
        logic              cin;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } dec_t;

    dec_t        dec;
    dec_t        sh;
    logic        sh_vld;
    logic        out_adv;
    logic        take;
    logic [31:0] n_reg;
    logic [L-1:0] n_imm;
    shift_type_t in_t;

    // Stage A: fold every special amount into (amt 0..W, pass, rrx, zero) so stage B is a plain shift.
    always_comb begin
        in_t     = shift_type_t'(in_type);
        n_reg    = 32'(in_amount);
        n_imm    = in_amount[L-1:0];
        dec      = '0;
        dec.typ  = in_t;
        dec.cin  = in_carry;
        dec.data = in_data;
        dec.tag  = in_tag;
        if (in_imm) begin
            dec.amt = EW'(n_imm);
            if (n_imm == '0) begin
                case (in_t)
                    SH_LSL:  dec.pass = 1'b1;
                    SH_ROR:  dec.rrx  = 1'b1;
                    default: dec.amt  = EW'(DATA_W);
                endcase
            end
        end else if (n_reg == '0) begin
            dec.pass = 1'b1;
        end else begin
            case (in_t)
                SH_ASR:  dec.amt = (n_reg >= W32) ? EW'(DATA_W) : n_reg[EW-1:0];
                SH_ROR:  dec.amt = EW'(n_reg[L-1:0]);
                default: begin
                    dec.amt  = n_reg[EW-1:0];
                    dec.zero = (n_reg > W32);
                end
            endcase
        end
    end

    assign out_adv = !out_valid || out_ready;

`ifdef ARM7_SHIFT_PIPE2_EN
    logic a_vld;
    dec_t a_q;

    assign sh       = a_q;
    assign sh_vld   = a_vld;
    assign in_ready = !flush && (!a_vld || out_adv);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            a_vld <= 1'b0;
        end else if (in_ready) begin
            a_vld <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            a_q <= dec;
        end
    end
`else
    assign sh       = dec;
    assign sh_vld   = in_valid;
    assign in_ready = !flush && out_adv;
`endif

    assign take = sh_vld && out_adv && !flush;

    // Stage B: the extra bit beside the operand catches the last bit shifted out, i.e. the carry.
    logic [DATA_W:0]        lsl_w;
    logic [DATA_W:0]        lsr_w;
    logic signed [DATA_W:0] asr_w;
    logic [DATA_W-1:0]      ror_w;
    logic [DATA_W-1:0]      res_data;
    logic                   res_carry;

    always_comb begin
        lsl_w     = {1'b0, sh.data} << sh.amt;
        lsr_w     = {sh.data, 1'b0} >> sh.amt;
        asr_w     = $signed({sh.data, 1'b0}) >>> sh.amt;
        ror_w     = DATA_W'({sh.data, sh.data} >> sh.amt);
        res_data  = sh.data;
        res_carry = sh.cin;
        if (sh.pass) begin
            res_data  = sh.data;
            res_carry = sh.cin;
        end else if (sh.rrx) begin
            res_data  = {sh.cin, sh.data[DATA_W-1:1]};
            res_carry = sh.data[0];
        end else if (sh.zero) begin
            res_data  = '0;
            res_carry = 1'b0;
        end else begin
            case (sh.typ)
                SH_LSL: begin
                    res_data  = lsl_w[DATA_W-1:0];
                    res_carry = lsl_w[DATA_W];
                end
                SH_LSR: begin
                    res_data  = lsr_w[DATA_W:1];
                    res_carry = lsr_w[0];
                end
                SH_ASR: begin
                    res_data  = asr_w[DATA_W:1];
                    res_carry = asr_w[0];
                end
                default: begin
                    res_data  = ror_w;
                    res_carry = ror_w[DATA_W-1];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (out_adv) begin
                out_valid <= sh_vld;
            end
            if (take) begin
                out_data  <= res_data;
                out_carry <= res_carry;
                out_tag   <= sh.tag;
            end
        end
    end
endmodule

// File: tb/tb_arm7tdmi_shift_pipe.sv
// Bench for arm7tdmi_shift_pipe: reference shifter model plus scoreboard on a 32-bit instance,
// directed literal cases on a 16-bit instance.
`timescale 1ns/1ps
module tb_arm7tdmi_shift_pipe;
`ifdef ARM7_SHIFT_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, in_imm, in_carry;
    logic        out_valid, out_ready, out_carry;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_type;
    logic [7:0]  in_amount;
    logic [3:0]  in_tag, out_tag;

    logic        v16, ir16, imm16, cin16, ov16, r16, oc16, fl16;
    logic [15:0] d16, od16;
    logic [1:0]  t16;
    logic [7:0]  a16;
    logic [3:0]  tg16, ot16;

    arm7tdmi_shift_pipe #(.DATA_W(32), .AMT_W(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_type(in_type),
        .in_amount(in_amount), .in_imm(in_imm), .in_carry(in_carry), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry), .out_tag(out_tag)
    );

    arm7tdmi_shift_pipe #(.DATA_W(16), .AMT_W(8), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst), .flush(fl16),
        .in_valid(v16), .in_ready(ir16), .in_data(d16), .in_type(t16),
        .in_amount(a16), .in_imm(imm16), .in_carry(cin16), .in_tag(tg16),
        .out_valid(ov16), .out_ready(r16), .out_data(od16),
        .out_carry(oc16), .out_tag(ot16)
    );

    int total = 0;
    int bad   = 0;
    int or_mode = 0;   // 0: out_ready high, 1: toggle each cycle, 2: left as the main sequence sets it

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic [3:0]  tag;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [31:0] d;
        int          t;
        int          a;
        bit          im;
        bit          c;
        logic [31:0] ed;
        bit          ec;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference shifter written straight from the ARM operand-2 rules; result is {carry, data}.
    function automatic logic [64:0] model(input int w, input logic [63:0] din, input int typ,
                                          input int amt, input bit imm, input bit cin);
        logic [63:0] mask, d, r;
        logic        c;
        int          n, rr;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d = din & mask;
        r = '0;
        c = 1'b0;
        n = imm ? (amt % w) : amt;
        if (imm && n == 0) begin
            if (typ == 0) return {cin, d};
            if (typ == 3) return {d[0], (64'(cin) << (w - 1)) | (d >> 1)};
            n = w;
        end
        if (n == 0) return {cin, d};
        case (typ)
            0: begin
                if (n < w) begin r = (d << n) & mask; c = d[w - n]; end
                else if (n == w) c = d[0];
            end
            1: begin
                if (n < w) begin r = d >> n; c = d[n - 1]; end
                else if (n == w) c = d[w - 1];
            end
            2: begin
                for (int i = 0; i < w; i++) r[i] = (i + n < w) ? d[i + n] : d[w - 1];
                c = (n < w) ? d[n - 1] : d[w - 1];
            end
            default: begin
                rr = n % w;
                if (rr == 0) begin r = d; c = d[w - 1]; end
                else begin r = ((d >> rr) | (d << (w - rr))) & mask; c = d[rr - 1]; end
            end
        endcase
        return {c, r};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (or_mode == 0) out_ready = 1'b1;
            else if (or_mode == 1) out_ready = ~out_ready;
        end
    end

    logic        stall_prev = 1'b0;
    logic        flush_prev = 1'b0;
    logic [36:0] held;
    logic [64:0] mm;
    exp_t        e;

    // Scoreboard: every output transfer must match the oldest accepted operation; stalls must hold.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && !flush_prev)
                    chk("hold", {out_valid, out_carry, out_tag, out_data}, {1'b1, held});
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", 72'(out_valid), 72'(0));
                    end else begin
                        e = q.pop_front();
                        chk("result", {out_carry, out_tag, out_data}, {e.c, e.tag, e.d});
                    end
                end
                if (flush) begin
                    chk("flush_in_ready", 72'(in_ready), 72'(0));
                    q.delete();
                end else if (in_valid && in_ready) begin
                    mm = model(32, 64'(in_data), int'(in_type), int'(in_amount), in_imm, in_carry);
                    q.push_back('{mm[31:0], mm[64], in_tag});
                end
                stall_prev = out_valid && !out_ready;
                held       = {out_carry, out_tag, out_data};
                flush_prev = flush;
            end
        end
    end

    task automatic send(input logic [31:0] d, input int t, input int a, input bit im,
                        input bit c, input logic [3:0] tg);
        int waited = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_type   = t[1:0];
        in_amount = a[7:0];
        in_imm    = im;
        in_carry  = c;
        in_tag    = tg;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stuck at %0d for tag %0d", in_ready, tg);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_all_results_out", 72'(q.size()), 72'(0));
    endtask

    task automatic lat32(input logic [3:0] tg);
        int n = 0;
        in_valid = 1'b1; in_data = 32'h0000_00F0; in_type = 2'd1; in_amount = 8'd4;
        in_imm = 1'b0; in_carry = 1'b0; in_tag = tg;
        do begin
            @(posedge clk);
            n++;
            #1;
            in_valid = 1'b0;
        end while (!out_valid && n < 10);
        chk("latency32", 72'(n), 72'(LAT));
        chk("latency32_result", {out_carry, out_data}, {1'b0, 32'h0000_000F});
    endtask

    task automatic run16(input string nm, input logic [15:0] d, input int t, input int a,
                         input bit im, input bit c, input logic [15:0] ed, input bit ec);
        int n = 0;
        v16 = 1'b1; d16 = d; t16 = t[1:0]; a16 = a[7:0]; imm16 = im; cin16 = c; tg16 = 4'hA;
        do begin
            @(posedge clk);
            n++;
            #1;
            v16 = 1'b0;
        end while (!ov16 && n < 10);
        chk({nm, "_latency"}, 72'(n), 72'(LAT));
        chk({nm, "_result"}, {oc16, ot16, od16}, {ec, 4'hA, ed});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_type = '0; in_amount = '0;
        in_imm = 1'b0; in_carry = 1'b0; in_tag = '0; out_ready = 1'b1;
        v16 = 1'b0; d16 = '0; t16 = '0; a16 = '0; imm16 = 1'b0; cin16 = 1'b0; tg16 = '0;
        r16 = 1'b1; fl16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 72'(out_valid), 72'(0));
        chk("reset_out_regs", {out_carry, out_tag, out_data}, 72'(0));
        chk("reset_in_ready", 72'(in_ready), 72'(1));
        chk("reset16", {ir16, ov16, oc16, ot16, od16}, {1'b1, 1'b0, 1'b0, 4'h0, 16'h0});
        @(posedge clk);
        #1;

        // d, type(0 LSL 1 LSR 2 ASR 3 ROR), amount, imm, carry_in, expected data, expected carry
        vq.push_back('{32'h8000_0001, 0, 32,  0, 0, 32'h0000_0000, 1});
        vq.push_back('{32'h8000_0001, 0, 33,  0, 0, 32'h0000_0000, 0});
        vq.push_back('{32'h8000_0001, 1, 32,  0, 0, 32'h0000_0000, 1});
        vq.push_back('{32'h8000_0001, 3, 64,  0, 0, 32'h8000_0001, 1});
        vq.push_back('{32'h8000_0000, 2, 200, 0, 0, 32'hFFFF_FFFF, 1});
        vq.push_back('{32'h1234_5678, 0, 0,   0, 1, 32'h1234_5678, 1});
        vq.push_back('{32'h1234_5678, 1, 0,   0, 1, 32'h1234_5678, 1});
        vq.push_back('{32'h1234_5678, 2, 0,   0, 1, 32'h1234_5678, 1});
        vq.push_back('{32'h1234_5678, 3, 0,   0, 1, 32'h1234_5678, 1});
        vq.push_back('{32'h0000_0003, 3, 0,   1, 1, 32'h8000_0001, 1});
        vq.push_back('{32'h0000_0003, 1, 0,   1, 1, 32'h0000_0000, 0});
        vq.push_back('{32'h8000_0000, 2, 0,   1, 1, 32'hFFFF_FFFF, 1});
        vq.push_back('{32'h8000_0001, 0, 4,   0, 0, 32'h0000_0010, 0});
        vq.push_back('{32'h0000_0003, 1, 1,   0, 0, 32'h0000_0001, 1});
        vq.push_back('{32'h0000_000F, 3, 4,   0, 0, 32'hF000_0000, 1});
        vq.push_back('{32'h8000_0000, 2, 4,   1, 0, 32'hF800_0000, 0});
        vq.push_back('{32'h8000_0001, 0, 33,  1, 0, 32'h0000_0002, 1});
        vq.push_back('{32'h4000_0000, 2, 31,  0, 0, 32'h0000_0000, 1});

        foreach (vq[i]) begin
            mm = model(32, 64'(vq[i].d), vq[i].t, vq[i].a, vq[i].im, vq[i].c);
            chk($sformatf("model_pin%0d", i), 72'(mm), 72'({vq[i].ec, 32'h0, vq[i].ed}));
            send(vq[i].d, vq[i].t, vq[i].a, vq[i].im, vq[i].c, 4'(i));
        end
        drain();

        lat32(4'hB);
        drain();

        // Back-pressure: 8 tagged ops with out_ready toggling
        or_mode = 1;
        for (int i = 0; i < 8; i++)
            send(32'hA5A5_0000 + 32'(i) * 32'h1111, i % 4, i * 5, i[0], i[1], 4'(i));
        drain();
        or_mode = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Flush with operations in flight and a valid input presented during the flush
        or_mode = 2;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_00FF; in_type = 2'd0; in_amount = 8'd1; in_imm = 1'b0; in_tag = 4'h8;
        @(posedge clk);
        #1;
        in_data = 32'h0000_0FF0; in_type = 2'd1; in_tag = 4'h9;
        @(posedge clk);
        #1;
        in_data = 32'h1111_1111; in_type = 2'd3; in_tag = 4'hA; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; or_mode = 0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_flush_out_valid%0d", i), 72'(out_valid), 72'(0));
        end
        @(posedge clk);
        #1;
        lat32(4'hC);
        drain();

        // Reset while a result is stalled at the output
        or_mode = 2;
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 1, 4, 0, 0, 4'hD);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out", {out_valid, out_carry, out_tag, out_data}, 72'(0));
        chk("midrst_in_ready", 72'(in_ready), 72'(1));
        or_mode = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // 16-bit instance
        run16("w16_lsr16", 16'h8001, 1, 16, 0, 0, 16'h0000, 1);
        run16("w16_ror20", 16'h123C, 3, 20, 0, 0, 16'hC123, 1);
        run16("w16_asr0",  16'h8000, 2, 0,  1, 0, 16'hFFFF, 1);
        run16("w16_lsl3",  16'h1234, 0, 3,  0, 0, 16'h91A0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
